// File: rtl/inst_gen.sv
// rtl/inst_gen.sv - LFSR-driven random instruction generator with checker pass/fail statistics
// Define INST_GEN_BRANCH_EN to also issue BEQ/BNE/J; otherwise only R-type/ADDI/LW/SW.
module inst_gen #(
    parameter logic [31:0] SEED     = 32'h1,
    parameter int unsigned NUM_INST = 64,
    parameter int unsigned CHK_LAT  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        OpDone,
    output logic [31:0] inst,
    output logic        pcEn,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_cnt,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt
);
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [15:0] LAST_INST = 16'(NUM_INST);
    localparam logic [3:0]  LAST_WAIT = 4'(CHK_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] inst_q, inst_d;
    logic        pc_en_q, pc_en_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] issued_q, issued_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] fail_q, fail_d;

    logic [2:0]  sel;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] enc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        sel = lfsr_q[2:0];
`ifndef INST_GEN_BRANCH_EN
        if (sel == 3'd4 || sel == 3'd5 || sel == 3'd6) begin
            sel = 3'd0;
        end
`endif
        case (lfsr_q[10:8])
            3'd1:    funct = 6'h22;
            3'd2:    funct = 6'h24;
            3'd3:    funct = 6'h27;
            3'd4:    funct = 6'h25;
            3'd5:    funct = 6'h2A;
            3'd6:    funct = 6'h13;
            default: funct = 6'h20;
        endcase
        imm = lfsr_q[31:16] ^ lfsr_q[15:0];
        case (sel)
            3'd1:    enc = {6'h08, lfsr_q[15:11], lfsr_q[20:16], imm};
            3'd2:    enc = {6'h23, lfsr_q[15:11], lfsr_q[20:16], imm};
            3'd3:    enc = {6'h2B, lfsr_q[15:11], lfsr_q[20:16], imm};
            3'd4:    enc = {6'h04, lfsr_q[15:11], lfsr_q[20:16], imm};
            3'd5:    enc = {6'h05, lfsr_q[15:11], lfsr_q[20:16], imm};
            3'd6:    enc = {6'h02, lfsr_q[25:0]};
            default: enc = {6'h00, lfsr_q[15:11], lfsr_q[20:16], lfsr_q[25:21], 5'h00, funct};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        wait_d   = wait_q;
        issued_d = issued_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    issued_d = 16'h0;
                    pass_d   = 16'h0;
                    fail_d   = 16'h0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wait_d  = 4'd0;
            end
            S_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == LAST_WAIT) begin
                    if (OpDone) pass_d = sat_inc(pass_q);
                    else        fail_d = sat_inc(fail_q);
                    state_d = (issued_q < LAST_INST) ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Issue on the edge entering ISSUE so the pcEn cycle is the ISSUE cycle.
        pc_en_d = (state_d == S_ISSUE);
        inst_d  = pc_en_d ? enc : 32'hFFFF_FFFF;
        if (pc_en_d) begin
            lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
            issued_d = sat_inc(issued_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_INIT;
            inst_q   <= 32'hFFFF_FFFF;
            pc_en_q  <= 1'b0;
            wait_q   <= 4'd0;
            issued_q <= 16'h0;
            pass_q   <= 16'h0;
            fail_q   <= 16'h0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            inst_q   <= inst_d;
            pc_en_q  <= pc_en_d;
            wait_q   <= wait_d;
            issued_q <= issued_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign inst       = inst_q;
    assign pcEn       = pc_en_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);
    assign issued_cnt = issued_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
endmodule
